// File: rtl/control_cmd_dispatch_if.sv
// Bundle between the command dispatcher, the upstream byte stream, the command engines and the RAM write port.
// The master side drives the stream and the engine outputs. The slave side is the dispatcher.
interface control_cmd_dispatch_if #(
    parameter int NUM_CMDS = 4,
    parameter int ROW_W    = 5,
    parameter int COL_W    = 6,
    parameter int PIX_W    = 1
);
    localparam int SEL_W = $clog2(NUM_CMDS);

    logic [7:0]              in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_CMDS-1:0]     sub_enable;
    logic [7:0]              sub_data;
    logic [NUM_CMDS-1:0]     sub_ready_for_data;
    logic [NUM_CMDS-1:0]     sub_done;
    logic [NUM_CMDS*ROW_W-1:0] sub_row;
    logic [NUM_CMDS*COL_W-1:0] sub_column;
    logic [NUM_CMDS*PIX_W-1:0] sub_pixel;
    logic [NUM_CMDS*8-1:0]   sub_data_out;
    logic [NUM_CMDS-1:0]     sub_ram_write_enable;
    logic [ROW_W-1:0]        row;
    logic [COL_W-1:0]        column;
    logic [PIX_W-1:0]        pixel;
    logic [7:0]              data_out;
    logic                    ram_write_enable;
    logic                    busy;
    logic [SEL_W-1:0]        active_cmd;
    logic                    cmd_error;
    logic                    cmd_timeout;

    modport master (
        output in_data, in_valid, sub_ready_for_data, sub_done, sub_row, sub_column,
               sub_pixel, sub_data_out, sub_ram_write_enable,
        input  in_ready, sub_enable, sub_data, row, column, pixel, data_out,
               ram_write_enable, busy, active_cmd, cmd_error, cmd_timeout
    );

    modport slave (
        input  in_data, in_valid, sub_ready_for_data, sub_done, sub_row, sub_column,
               sub_pixel, sub_data_out, sub_ram_write_enable,
        output in_ready, sub_enable, sub_data, row, column, pixel, data_out,
               ram_write_enable, busy, active_cmd, cmd_error, cmd_timeout
    );
endinterface

// File: rtl/control_cmd_dispatch.sv
// Command front-end: decodes an opcode byte and streams the payload to the selected engine.
// It muxes that engine's framebuffer write port, and a no-progress watchdog aborts stalled engines.
//   state | meaning
//   IDLE  | waiting for an opcode byte
//   RUN   | payload forwarded to engine active_cmd, watchdog running
//   DRAIN | single cycle with the engine disabled; its write port is still muxed
module control_cmd_dispatch #(
    parameter int                    NUM_CMDS       = 4,
    parameter logic [NUM_CMDS*8-1:0] OPCODES        = 32'h52_4C_50_46,
    parameter int                    ROW_W          = 5,
    parameter int                    COL_W          = 6,
    parameter int                    PIX_W          = 1,
    parameter int                    TIMEOUT_CYCLES = 1024
) (
    input logic                   clk,
    input logic                   reset,
    control_cmd_dispatch_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_CMDS);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q;
    logic [SEL_W-1:0] active_q;
    logic [WD_W-1:0]  wd_q;
    logic             err_q;
    logic             tmo_q;

    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic             sel_rdy;
    logic             sel_done;
    logic             sel_we;
    logic             accept;
    logic             progress;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (bus.in_data == OPCODES[8*i +: 8]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign sel_rdy  = bus.sub_ready_for_data[active_q];
    assign sel_done = bus.sub_done[active_q];
    assign sel_we   = bus.sub_ram_write_enable[active_q];
    assign accept   = bus.in_valid & bus.in_ready;
    assign progress = accept | bus.ram_write_enable;

    // An engine that is busy (not requesting) keeps running. A requesting engine only runs when a byte is really there.
    always_comb begin
        bus.in_ready         = 1'b0;
        bus.sub_enable       = '0;
        bus.row              = '0;
        bus.column           = '0;
        bus.pixel            = '0;
        bus.data_out         = '0;
        bus.ram_write_enable = 1'b0;
        if (state_q != IDLE) begin
            bus.row              = bus.sub_row[active_q*ROW_W +: ROW_W];
            bus.column           = bus.sub_column[active_q*COL_W +: COL_W];
            bus.pixel            = bus.sub_pixel[active_q*PIX_W +: PIX_W];
            bus.data_out         = bus.sub_data_out[active_q*8 +: 8];
            bus.ram_write_enable = sel_we;
        end
        if (state_q == IDLE) begin
            bus.in_ready = reset;
        end
        if (state_q == RUN) begin
            bus.in_ready             = sel_rdy;
            bus.sub_enable[active_q] = !sel_rdy || bus.in_valid;
        end
    end

    assign bus.sub_data    = bus.in_data;
    assign bus.busy        = (state_q != IDLE);
    assign bus.active_cmd  = active_q;
    assign bus.cmd_error   = err_q;
    assign bus.cmd_timeout = tmo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            active_q <= '0;
            wd_q     <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (hit) begin
                            active_q <= hit_idx;
                            wd_q     <= '0;
                            state_q  <= RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // A completion in the same cycle as the timeout takes priority over it.
                    if (sel_done) begin
                        state_q <= DRAIN;
                    end else if (progress) begin
                        wd_q <= '0;
                    end else if (wd_q == WD_LAST) begin
                        tmo_q   <= 1'b1;
                        state_q <= DRAIN;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_control_cmd_dispatch.sv
// Directed bench for control_cmd_dispatch: the bench itself stands in for the four engines.
// Each task drives a scenario and checks the expected outputs cycle by cycle.
module tb_control_cmd_dispatch;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_cmd_dispatch_if #(.NUM_CMDS(4), .ROW_W(5), .COL_W(6), .PIX_W(1)) bus ();

    control_cmd_dispatch #(
        .NUM_CMDS(4), .OPCODES(32'h52_4C_50_46), .ROW_W(5), .COL_W(6), .PIX_W(1),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Inputs change 1 time unit after the rising edge. Outputs are sampled 2 units after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_engines();
        bus.in_valid             = 1'b0;
        bus.in_data              = 8'h00;
        bus.sub_ready_for_data   = 4'b0000;
        bus.sub_done             = 4'b0000;
        bus.sub_ram_write_enable = 4'b0000;
        bus.sub_row              = {5'd4, 5'd3, 5'd2, 5'd1};
        bus.sub_column           = {6'd40, 6'd30, 6'd20, 6'd10};
        bus.sub_pixel            = 4'b1010;
        bus.sub_data_out         = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_engines();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %0h exp 0", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", bus.busy); end
        checks++; if (bus.sub_enable !== 4'b0000) begin errors++; $display("FAIL rst_sub_enable got %b exp 0000", bus.sub_enable); end
        checks++; if (bus.active_cmd !== 2'd0) begin errors++; $display("FAIL rst_active got %0d exp 0", bus.active_cmd); end
        checks++; if ({bus.cmd_error, bus.cmd_timeout, bus.ram_write_enable} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b exp 000", {bus.cmd_error, bus.cmd_timeout, bus.ram_write_enable}); end
        @(negedge clk);
        reset = 1'b1;
        step(); #2;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %0h exp 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int acc = 0;
        bus.in_data = 8'h46; bus.in_valid = 1'b1; #2;
        checks++; if (bus.sub_enable !== 4'b0000) begin errors++; $display("FAIL basic_idle_en got %b exp 0000", bus.sub_enable); end
        step();
        bus.in_data = 8'hCA; bus.sub_ready_for_data = 4'b0001; #2;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %0h exp 1", bus.busy); end
        checks++; if (bus.active_cmd !== 2'd0) begin errors++; $display("FAIL basic_active got %0d exp 0", bus.active_cmd); end
        checks++; if (bus.sub_enable !== 4'b0001) begin errors++; $display("FAIL basic_en_t1 got %b exp 0001", bus.sub_enable); end
        checks++; if (bus.sub_data !== 8'hCA) begin errors++; $display("FAIL basic_data0 got %h exp ca", bus.sub_data); end
        if (bus.in_valid && bus.in_ready) acc++;
        step();
        bus.in_data = 8'hFE; #2;
        checks++; if (bus.sub_data !== 8'hFE) begin errors++; $display("FAIL basic_data1 got %h exp fe", bus.sub_data); end
        if (bus.in_valid && bus.in_ready) acc++;
        step();
        bus.in_valid = 1'b0; bus.sub_ready_for_data = 4'b0000; bus.sub_ram_write_enable = 4'b0001; #2;
        if (bus.in_valid && bus.in_ready) acc++;
        checks++; if (bus.ram_write_enable !== 1'b1) begin errors++; $display("FAIL basic_we got %0h exp 1", bus.ram_write_enable); end
        checks++; if ({bus.row, bus.column, bus.pixel, bus.data_out} !== {5'd1, 6'd10, 1'b0, 8'hD0}) begin errors++; $display("FAIL basic_ram_port got %h exp %h", {bus.row, bus.column, bus.pixel, bus.data_out}, {5'd1, 6'd10, 1'b0, 8'hD0}); end
        checks++; if (bus.sub_enable !== 4'b0001) begin errors++; $display("FAIL basic_en_busy got %b exp 0001", bus.sub_enable); end
        step();
        bus.sub_ram_write_enable = 4'b0000; bus.sub_done = 4'b0001; #2;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_done got %0h exp 1", bus.busy); end
        step();
        bus.sub_done = 4'b0000; bus.sub_ram_write_enable = 4'b0001; #2;
        checks++; if ({bus.busy, bus.sub_enable, bus.in_ready} !== 6'b1_0000_0) begin errors++; $display("FAIL basic_drain got %b exp 100000", {bus.busy, bus.sub_enable, bus.in_ready}); end
        checks++; if (bus.ram_write_enable !== 1'b1) begin errors++; $display("FAIL basic_drain_we got %0h exp 1", bus.ram_write_enable); end
        step();
        bus.sub_ram_write_enable = 4'b0000; #2;
        checks++; if ({bus.busy, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL basic_idle got %b exp 01", {bus.busy, bus.in_ready}); end
        checks++; if ({bus.row, bus.data_out} !== 13'd0) begin errors++; $display("FAIL basic_idle_ram got %h exp 0", {bus.row, bus.data_out}); end
        checks++; if (acc !== 2) begin errors++; $display("FAIL basic_bytes got %0d exp 2", acc); end
    endtask

    task automatic test_error();
        bus.in_data = 8'h99; bus.in_valid = 1'b1; #2;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL err_in_ready got %0h exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0; #2;
        checks++; if ({bus.cmd_error, bus.busy, bus.in_ready} !== 3'b101) begin errors++; $display("FAIL err_pulse got %b exp 101", {bus.cmd_error, bus.busy, bus.in_ready}); end
        step(); #2;
        checks++; if (bus.cmd_error !== 1'b0) begin errors++; $display("FAIL err_once got %0h exp 0", bus.cmd_error); end
        bus.in_data = 8'h50; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; #2;
        checks++; if (bus.active_cmd !== 2'd1) begin errors++; $display("FAIL err_next_active got %0d exp 1", bus.active_cmd); end
        checks++; if (bus.sub_enable !== 4'b0010) begin errors++; $display("FAIL err_next_en got %b exp 0010", bus.sub_enable); end
        bus.sub_done = 4'b0010;
        step();
        bus.sub_done = 4'b0000;
        step(); #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_exit got %0h exp 0", bus.busy); end
    endtask

    // Stall kept below the 16-cycle watchdog of this instance.
    task automatic test_stall();
        int bad = 0;
        bus.in_data = 8'h4C; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.sub_ready_for_data = 4'b0100; #2;
        for (int i = 0; i < 12; i++) begin
            if (bus.sub_enable !== 4'b0000 || bus.busy !== 1'b1) bad++;
            step(); #2;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stall_paused got %0d bad cycles exp 0", bad); end
        bus.in_data = 8'h11; bus.in_valid = 1'b1; #1;
        checks++; if ({bus.sub_enable, bus.in_ready, bus.sub_data} !== {4'b0100, 1'b1, 8'h11}) begin errors++; $display("FAIL stall_resume0 got %h exp %h", {bus.sub_enable, bus.in_ready, bus.sub_data}, {4'b0100, 1'b1, 8'h11}); end
        step();
        bus.in_data = 8'h22; #2;
        checks++; if ({bus.sub_enable, bus.in_ready, bus.sub_data} !== {4'b0100, 1'b1, 8'h22}) begin errors++; $display("FAIL stall_resume1 got %h exp %h", {bus.sub_enable, bus.in_ready, bus.sub_data}, {4'b0100, 1'b1, 8'h22}); end
        step();
        bus.in_valid = 1'b0; bus.sub_ready_for_data = 4'b0000; bus.sub_done = 4'b0100; #2;
        checks++; if (bus.cmd_timeout !== 1'b0) begin errors++; $display("FAIL stall_no_timeout got %0h exp 0", bus.cmd_timeout); end
        step();
        bus.sub_done = 4'b0000;
        step(); #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_exit got %0h exp 0", bus.busy); end
    endtask

    task automatic test_timeout();
        int early = 0;
        bus.in_data = 8'h52; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.sub_ram_write_enable = 4'b1000; #2;
        checks++; if (bus.ram_write_enable !== 1'b1) begin errors++; $display("FAIL tmo_progress_we got %0h exp 1", bus.ram_write_enable); end
        step();
        bus.sub_ram_write_enable = 4'b0000;
        for (int k = 0; k < 16; k++) begin
            #2;
            if (bus.cmd_timeout !== 1'b0 || bus.busy !== 1'b1) early++;
            step();
        end
        checks++; if (early !== 0) begin errors++; $display("FAIL tmo_early got %0d bad cycles exp 0", early); end
        #2;
        checks++; if ({bus.cmd_timeout, bus.busy, bus.sub_enable} !== 6'b11_0000) begin errors++; $display("FAIL tmo_pulse got %b exp 110000", {bus.cmd_timeout, bus.busy, bus.sub_enable}); end
        step(); #2;
        checks++; if ({bus.cmd_timeout, bus.busy} !== 2'b00) begin errors++; $display("FAIL tmo_idle got %b exp 00", {bus.cmd_timeout, bus.busy}); end
        // Completion arrives in the very cycle the watchdog would expire.
        early = 0;
        bus.in_data = 8'h52; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            #2;
            if (bus.cmd_timeout !== 1'b0) early++;
            step();
        end
        bus.sub_done = 4'b1000;
        step();
        bus.sub_done = 4'b0000; #2;
        checks++; if ({bus.cmd_timeout, bus.busy, bus.sub_enable} !== 6'b01_0000) begin errors++; $display("FAIL tmo_done_wins got %b exp 010000 (early %0d)", {bus.cmd_timeout, bus.busy, bus.sub_enable}, early); end
        step(); #2;
        checks++; if ({bus.cmd_timeout, bus.busy} !== 2'b00) begin errors++; $display("FAIL tmo_done_idle got %b exp 00", {bus.cmd_timeout, bus.busy}); end
    endtask

    task automatic test_keepalive();
        int bad = 0;
        bus.in_data = 8'h46; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            bus.sub_ram_write_enable = (k % 8 == 0) ? 4'b0001 : 4'b0000;
            #2;
            if (bus.cmd_timeout !== 1'b0 || bus.busy !== 1'b1) bad++;
            step();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL keepalive got %0d bad cycles exp 0", bad); end
        bus.sub_ram_write_enable = 4'b0000; bus.sub_done = 4'b0001;
        step();
        bus.sub_done = 4'b0000;
        step(); #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL keepalive_exit got %0h exp 0", bus.busy); end
    endtask

    task automatic test_nonselected();
        bus.in_data = 8'h46; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.sub_ram_write_enable = 4'b0100; bus.sub_done = 4'b0100; #2;
        checks++; if (bus.ram_write_enable !== 1'b0) begin errors++; $display("FAIL nonsel_we got %0h exp 0", bus.ram_write_enable); end
        checks++; if (bus.data_out !== 8'hD0) begin errors++; $display("FAIL nonsel_data got %h exp d0", bus.data_out); end
        step();
        bus.sub_ram_write_enable = 4'b0000; bus.sub_done = 4'b0000; #2;
        checks++; if ({bus.busy, bus.sub_enable} !== 5'b1_0001) begin errors++; $display("FAIL nonsel_done_ignored got %b exp 10001", {bus.busy, bus.sub_enable}); end
        bus.sub_done = 4'b0001;
        step();
        bus.sub_done = 4'b0000;
        step(); #2;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nonsel_exit got %0h exp 0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        bus.in_data = 8'h4C; bus.in_valid = 1'b1;
        step();
        bus.in_data = 8'hCA; bus.sub_ready_for_data = 4'b0100; #2;
        checks++; if ({bus.active_cmd, bus.in_ready} !== 3'b10_1) begin errors++; $display("FAIL rmid_run got %b exp 101", {bus.active_cmd, bus.in_ready}); end
        step();
        bus.in_data = 8'hFE; bus.sub_ram_write_enable = 4'b0100;
        #1; reset = 1'b0; #1;
        checks++; if ({bus.busy, bus.sub_enable, bus.in_ready, bus.ram_write_enable} !== 7'd0) begin errors++; $display("FAIL rmid_outputs got %b exp 0000000", {bus.busy, bus.sub_enable, bus.in_ready, bus.ram_write_enable}); end
        checks++; if ({bus.active_cmd, bus.row, bus.data_out} !== 15'd0) begin errors++; $display("FAIL rmid_regs got %h exp 0", {bus.active_cmd, bus.row, bus.data_out}); end
        clear_engines();
        @(negedge clk);
        reset = 1'b1;
        step(); #2;
        checks++; if ({bus.busy, bus.in_ready} !== 2'b01) begin errors++; $display("FAIL rmid_idle got %b exp 01", {bus.busy, bus.in_ready}); end
        bus.in_data = 8'h50; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; #2;
        checks++; if ({bus.busy, bus.active_cmd} !== 3'b1_01) begin errors++; $display("FAIL rmid_next got %b exp 101", {bus.busy, bus.active_cmd}); end
        bus.sub_done = 4'b0010;
        step();
        bus.sub_done = 4'b0000;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_stall();
        test_timeout();
        test_keepalive();
        test_nonselected();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got no finish exp finish before 500000");
        $fatal(1, "bench time limit");
    end
endmodule
